// File: rtl/hex_display_ctrl.sv
// Seven-segment controller: renders a binary value in hex or decimal (double-dabble) on NUM_DIGITS active-low digits.
// Optional leading-zero blanking is enabled by defining HEX_DISP_LZB_EN.
module hex_display_ctrl #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned DATA_W     = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_mode,
    input  logic                    in_blank,
    output logic [7*NUM_DIGITS-1:0] hex_n,
    output logic                    overflow,
    output logic                    busy
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned HEX_W = 7 * NUM_DIGITS;
    localparam int unsigned EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              accept_c;
    logic [DATA_W-1:0] data_q;
    logic              mode_q;
    logic              blank_q;
    logic [BCD_W-1:0]  bcd_q;
    logic              carry_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [BCD_W-1:0]  bcd_adj_c;
    logic              add_carry_c;
    logic [HEX_W-1:0]  disp_c;
    logic              ovf_c;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        seg7 = SEG_BLANK;
        case (d)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_c) state_nxt = (in_mode && !in_blank) ? CONV : LOAD;
            CONV: if (cnt_q == CNT_LAST) state_nxt = LOAD;
            LOAD: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered decodes of the upcoming state; both low in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            in_ready <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
        end
    end

    // Add 3 to every BCD digit >= 5 ahead of the shift.
    always_comb begin : bcd_adjust
        logic [4:0] sum;
        bcd_adj_c   = '0;
        add_carry_c = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            sum = {1'b0, bcd_q[4*i +: 4]};
            if (bcd_q[4*i +: 4] >= 4'd5) sum = sum + 5'd3;
            bcd_adj_c[4*i +: 4] = sum[3:0];
            add_carry_c         = add_carry_c | sum[4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            mode_q  <= 1'b0;
            blank_q <= 1'b0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept_c) begin
            data_q  <= in_data;
            mode_q  <= in_mode;
            blank_q <= in_blank;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state == CONV) begin
            data_q  <= data_q << 1;
            bcd_q   <= {bcd_adj_c[BCD_W-2:0], data_q[DATA_W-1]};
            carry_q <= carry_q | add_carry_c | bcd_adj_c[BCD_W-1];
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Display image presented to the output register in LOAD.
    always_comb begin : render
        logic [EXT_W-1:0] ext;
        logic [BCD_W-1:0] src;
        logic             seen;
        ext    = EXT_W'(data_q);
        src    = mode_q ? bcd_q : ext[BCD_W-1:0];
        ovf_c  = mode_q ? carry_q : (|(ext >> BCD_W));
        disp_c = '1;
        seen   = 1'b0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            seen = seen | (src[4*k +: 4] != 4'd0) | (k == 0);
`ifdef HEX_DISP_LZB_EN
            disp_c[7*k +: 7] = seen ? seg7(src[4*k +: 4]) : SEG_BLANK;
`else
            disp_c[7*k +: 7] = seg7(src[4*k +: 4]);
`endif
        end
        if (blank_q) begin
            disp_c = '1;
            ovf_c  = 1'b0;
        end else if (ovf_c) begin
            disp_c = {NUM_DIGITS{SEG_DASH}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_n    <= '1;
            overflow <= 1'b0;
        end else if (state == LOAD) begin
            hex_n    <= disp_c;
            overflow <= ovf_c;
        end
    end

endmodule
